// File: rtl/dkong_video_pkg.sv
// rtl/dkong_video_pkg.sv - shared video-subsystem types and object-DMA defaults
package dkong_video_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    RD,
    WR,
    REL
  } obj_dma_state_t;

  localparam logic [15:0] OBJ_DMA_SRC_DEFAULT = 16'h6900;
  localparam logic [9:0]  OBJ_DMA_DST_DEFAULT = 10'h000;
  localparam int          OBJ_DMA_LEN_DEFAULT = 384;

endpackage

// File: rtl/dkong_obj_dma.sv
// rtl/dkong_obj_dma.sv - vblank object-RAM DMA scheduler (work RAM -> object RAM)
// Optional build macro: DKONG_OBJ_DMA_ABORT_EN (dma_ena low aborts after the current byte)
module dkong_obj_dma
  import dkong_video_pkg::*;
#(
  parameter logic [15:0] SRC_BASE = OBJ_DMA_SRC_DEFAULT,
  parameter logic [9:0]  DST_BASE = OBJ_DMA_DST_DEFAULT,
  parameter int          XFER_LEN = OBJ_DMA_LEN_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_ce,
  input  logic        vblk,
  input  logic        dma_ena,
  output logic        busrq_n,
  input  logic        busak_n,
  output logic [15:0] src_addr,
  output logic        src_rdn,
  input  logic [7:0]  src_din,
  output logic [9:0]  obj_addr,
  output logic        obj_wrn,
  output logic [7:0]  obj_dout,
  output logic        dma_busy,
  output logic        dma_done
);

  localparam logic [9:0] LAST = 10'(XFER_LEN - 1);

  obj_dma_state_t state, state_nxt;
  logic [9:0] cnt, cnt_nxt;
  logic       pend, vblk_q, trig;
`ifdef DKONG_OBJ_DMA_ABORT_EN
  logic       abort_q, abort_nxt;
`endif

  // edges arriving while a transfer is running are dropped, not queued
  assign trig = vblk & ~vblk_q & dma_ena & ~dma_busy;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
`ifdef DKONG_OBJ_DMA_ABORT_EN
    abort_nxt = abort_q;
`endif
    if (cpu_ce) begin
      case (state)
        IDLE: if (pend) begin
          state_nxt = REQ;
          cnt_nxt   = '0;
`ifdef DKONG_OBJ_DMA_ABORT_EN
          abort_nxt = 1'b0;
`endif
        end
        REQ: if (!busak_n) state_nxt = RD;
        RD: begin
          if (busak_n) state_nxt = REL;
          else begin
            state_nxt = WR;
`ifdef DKONG_OBJ_DMA_ABORT_EN
            if (!dma_ena) abort_nxt = 1'b1;
`endif
          end
        end
        WR: begin
          if (busak_n || cnt == LAST) state_nxt = REL;
`ifdef DKONG_OBJ_DMA_ABORT_EN
          else if (abort_q || !dma_ena) state_nxt = REL;
`endif
          else begin
            state_nxt = RD;
            cnt_nxt   = cnt + 10'd1;
          end
        end
        REL: if (busak_n) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // outputs are registered from the next state so they line up with the state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      pend     <= 1'b0;
      vblk_q   <= vblk;
      busrq_n  <= 1'b1;
      src_rdn  <= 1'b1;
      obj_wrn  <= 1'b1;
      src_addr <= SRC_BASE;
      obj_addr <= DST_BASE;
      obj_dout <= '0;
      dma_busy <= 1'b0;
      dma_done <= 1'b0;
`ifdef DKONG_OBJ_DMA_ABORT_EN
      abort_q  <= 1'b0;
`endif
    end else begin
      vblk_q <= vblk;
      state  <= state_nxt;
      cnt    <= cnt_nxt;
`ifdef DKONG_OBJ_DMA_ABORT_EN
      abort_q <= abort_nxt;
`endif
      if (state == IDLE && state_nxt == REQ) pend <= 1'b0;
      else if (trig)                         pend <= 1'b1;
      busrq_n <= !(state_nxt inside {REQ, RD, WR});
      src_rdn <= (state_nxt != RD);
      obj_wrn <= (state_nxt != WR);
      if (state_nxt == RD) src_addr <= SRC_BASE + {6'd0, cnt_nxt};
      if (state == RD && state_nxt == WR) begin
        obj_addr <= DST_BASE + cnt_nxt;
        obj_dout <= src_din;
      end
      dma_busy <= (state_nxt != IDLE);
      dma_done <= (state == REL && state_nxt == IDLE);
    end
  end

endmodule

// File: doc/dkong_obj_dma.md
# dkong_obj_dma

Object-RAM DMA scheduler for the Donkey Kong video subsystem. At the start of each vertical blank it requests the Z80 bus and copies the CPU's sprite staging table from work RAM into the sprite generator's object RAM. It then hands the bus back. It sits between the CPU bus arbiter, the work-RAM read port and the object-RAM write port. It replaces the discrete DMA controller of the original board.

## Interface
Parameters:
- SRC_BASE, 16'h6900, work-RAM source start address
- DST_BASE, 10'h000, object-RAM destination start address
- XFER_LEN, 384, bytes per transfer; legal range 1..1023

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- cpu_ce  in  1  one-clk strobe per CPU clock (1H rising); all bus-side state advances only on cpu_ce
- vblk  in  1  vertical blank level from video timing
- dma_ena  in  1  DMA enable latch (7D85h bit 0)
- busrq_n  out  1  Z80 bus request, active low
- busak_n  in  1  Z80 bus acknowledge, active low
- src_addr  out  16  work-RAM read address
- src_rdn  out  1  work-RAM read strobe, active low
- src_din  in  8  work-RAM read data, valid in the same cpu_ce step as src_rdn low
- obj_addr  out  10  object-RAM write address
- obj_wrn  out  1  object-RAM write strobe, active low
- obj_dout  out  8  object-RAM write data
- dma_busy  out  1  high from leaving IDLE until return to IDLE
- dma_done  out  1  one-clk pulse when a transfer completes and the bus is released

## Operation
- Trigger: vblk rising edge, detected on clk against a registered copy, with dma_ena=1 sets pend. Edges with dma_ena=0 are ignored. Edges while dma_busy=1 are dropped, and pend is not set.
- FSM states: IDLE, REQ, RD, WR, REL.
- IDLE: if pend and cpu_ce, clear pend, clear cnt, go to REQ.
- REQ: busrq_n=0. On cpu_ce with busak_n=0, go to RD.
- RD: src_addr=SRC_BASE+cnt, src_rdn=0. On cpu_ce, latch src_din into the data register and go to WR.
- WR: obj_addr=DST_BASE+cnt (10-bit wrap), obj_dout=data register, obj_wrn=0. On cpu_ce: if cnt==XFER_LEN-1 go to REL, else cnt+1 and go to RD.
- REL: busrq_n=1, strobes inactive. On cpu_ce with busak_n=1, pulse dma_done and go to IDLE.
- cnt is 10 bits. src_addr is computed in 16 bits and wraps modulo 2^16. obj_addr wraps modulo 1024.
- busrq_n stays low in REQ, RD and WR. Address buses hold their last value when their strobe is inactive.
- vblk falling mid-transfer has no effect; the transfer completes.
- busak_n rising while in RD or WR is a protocol error. The FSM goes directly to REL without completing the byte in flight.

## Timing
- Reset values: busrq_n=1, src_rdn=1, obj_wrn=1, src_addr=SRC_BASE, obj_addr=DST_BASE, obj_dout=0, dma_busy=0, dma_done=0, FSM=IDLE, pend=0, cnt=0.
- Reset mid-transfer releases the bus on the next clk. The partially written object RAM is left as is.
- All outputs are registered.
- Trigger to busrq_n low: at most 1 cpu_ce + 2 clk.
- Each byte costs exactly 2 cpu_ce steps (RD, WR).
- Total bus hold = 2·XFER_LEN cpu_ce steps plus grant latency. For XFER_LEN=384 at 3.072 MHz this is 250 µs, well inside vblank.
- dma_done pulses on the clk where the FSM enters IDLE.
- pend and cpu_ce in the same clk: IDLE→REQ on that clk.

## Configuration
- DKONG_OBJ_DMA_ABORT_EN defined: dma_ena=0 sampled on cpu_ce in RD or WR finishes the current byte's WR, then goes to REL. dma_done still pulses.
- Not defined: dma_ena is sampled only at trigger time, and a started transfer always runs to XFER_LEN.

## Structure
- dkong_video_pkg holds:
  - the obj_dma_state_t enum (IDLE, REQ, RD, WR, REL);
  - the OBJ_DMA_SRC_DEFAULT, OBJ_DMA_DST_DEFAULT and OBJ_DMA_LEN_DEFAULT constants.
- No sub-module; the edge detect and counter are inline. A single always_ff for state/cnt/pend and registered outputs, plus an always_comb for next-state logic.

## Test plan
- Nominal: fill 6900h–6A7Fh with ramp (addr low byte), dma_ena=1, pulse vblk, grant after 3 ce → obj RAM 000h–17Fh equals ramp, 768 ce between grant and REL, one dma_done, busrq_n=1 after.
- Disabled: dma_ena=0, vblk edge → busrq_n stays 1, no strobes, dma_busy=0.
- Retrigger: second vblk edge at byte 100 → ignored; exactly one transfer and one dma_done.
- Reset mid-transfer at byte 50 → next clk busrq_n=1, src_rdn=1, obj_wrn=1, dma_busy=0; next vblk edge restarts at cnt=0.
- Lost grant: busak_n→1 during byte 10 RD → REL, no write of byte 10, dma_done pulses.
- With DKONG_OBJ_DMA_ABORT_EN: dma_ena→0 during byte 20 RD → byte 20 written, byte 21 not, bus released.
